// File: rtl/e_mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer that owns HI/LO and stalls the pipe via busy.
// Optional MDU_FLUSH_EN adds a flush input that aborts an in-flight op or squashes a start.
module e_mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [63:0] mul64(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        ax = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        bx = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}. The divisor is forced to 1 for the zero and
    // most-negative/-1 cases so the divider never traps; /1 yields the wrapped
    // 0x80000000 quotient and zero remainder, and the zero case is discarded by the caller.
    function automatic logic [63:0] div32(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        logic [31:0] d;
        logic [31:0] q;
        logic [31:0] r;
        d = ((b == 32'd0) || (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))
            ? 32'd1 : b;
        if (sgn) begin
            sa = a;
            sd = d;
            q  = sa / sd;
            r  = sa % sd;
        end else begin
            q = a / d;
            r = a % d;
        end
        return {r, q};
    endfunction

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [2:0]       op_p0;
    logic [31:0]      a_p0;
    logic [31:0]      b_p0;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic [63:0]      prod;
    logic [63:0]      quo_rem;
    logic             kill;
    logic             is_md;
    logic             accept;

`ifdef MDU_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    assign is_md  = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
    assign accept = (state == IDLE) && start && !kill;

    // Operand capture stage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (accept && is_md) begin
            op_p0 <= mdu_op;
            a_p0  <= A;
            b_p0  <= B;
        end
    end

    // Commit value stage: divide by zero keeps the current HI/LO
    always_comb begin
        res_hi  = hi;
        res_lo  = lo;
        prod    = '0;
        quo_rem = '0;
        if ((op_p0 == OP_MULT) || (op_p0 == OP_MULTU)) begin
            prod   = mul64(op_p0 == OP_MULT, a_p0, b_p0);
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (b_p0 != 32'd0) begin
            quo_rem = div32(op_p0 == OP_DIV, a_p0, b_p0);
            res_hi  = quo_rem[63:32];
            res_lo  = quo_rem[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                if (is_md) begin
                    state <= RUN;
                    cnt   <= (mdu_op <= OP_MULTU) ? MULT_CNT : DIV_CNT;
                end else if (mdu_op == OP_MTHI) begin
                    hi <= A;
                end else if (mdu_op == OP_MTLO) begin
                    lo <= A;
                end
            end
        end else begin
            if (kill) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (cnt == CNT_ONE) begin
                state <= IDLE;
                cnt   <= '0;
                hi    <= res_hi;
                lo    <= res_lo;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign busy   = (state == RUN);
    assign hi_out = hi;
    assign lo_out = lo;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: stimulus queues expected results, a monitor
// checks them whenever busy drops. Define MDU_FLUSH_EN to also exercise flush.
module tb_e_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
`ifdef MDU_FLUSH_EN
    logic        flush = 1'b0;
`endif

    e_mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .A      (A),
        .B      (B),
`ifdef MDU_FLUSH_EN
        .flush  (flush),
`endif
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_op(input string name, input int lat, input logic [31:0] h,
                             input logic [31:0] l);
        exp_t e;
        e.name = name;
        e.lat  = lat;
        e.hi   = h;
        e.lo   = l;
        q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        A      = a;
        B      = b;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 3'd0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            n_cmp++;
            $display("FAIL timeout: %0d ops outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: a busy 1->0 transition presents a result
    int bcnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
        end else if (bcnt != 0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_busy: busy ran %0d cycles, required 0", bcnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_lat"}, 32'(bcnt), 32'(e.lat));
                check({e.name, "_hi"}, hi_out, e.hi);
                check({e.name, "_lo"}, lo_out, e.lo);
            end
            bcnt = 0;
        end
    end

    initial begin
        #1 reset = 1'b0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        #9 reset = 1'b1;

        issue(3'd5, 32'h1234_5678, 32'd0);
        check("mthi_hi", hi_out, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_lo", lo_out, 32'h9ABC_DEF0);
        check("mtlo_hi", hi_out, 32'h1234_5678);

        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("none_hi", hi_out, 32'h1234_5678);
        check("none_lo", lo_out, 32'h9ABC_DEF0);

        expect_op("div0", 10, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(3'd3, 32'd5, 32'd0);
        wait_idle();

        expect_op("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(3'd1, 32'hFFFF_FFFD, 32'd5);
        wait_idle();
        expect_op("multu", 5, 32'h0000_0004, 32'hFFFF_FFF1);
        issue(3'd2, 32'hFFFF_FFFD, 32'd5);
        wait_idle();

        expect_op("divu", 10, 32'd1, 32'd3);
        issue(3'd4, 32'd7, 32'd2);
        wait_idle();
        expect_op("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        expect_op("div_ovf", 10, 32'd0, 32'h8000_0000);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        expect_op("mult_ignore", 5, 32'd0, 32'd6);
        issue(3'd1, 32'd2, 32'd3);
        issue(3'd4, 32'd9, 32'd3);
        wait_idle();

`ifdef MDU_FLUSH_EN
        expect_op("flush_run", 3, 32'd0, 32'd6);
        issue(3'd1, 32'd7, 32'd7);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        wait_idle();
        @(negedge clk);
        start  = 1'b1;
        mdu_op = 3'd5;
        A      = 32'h0000_DEAD;
        flush  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 3'd0;
        flush  = 1'b0;
        check("flush_mthi", hi_out, 32'd0);
`endif

        issue(3'd5, 32'h0000_0055, 32'd0);
        check("pre_rst_hi", hi_out, 32'h0000_0055);
        issue(3'd1, 32'd4, 32'd4);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrun_busy", {31'd0, busy}, 32'd0);
        check("midrun_hi", hi_out, 32'd0);
        check("midrun_lo", lo_out, 32'd0);
        #14 reset = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_hi", hi_out, 32'd0);
        check("post_rst_lo", lo_out, 32'd0);

        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
